// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS main control: opcodes, ALUOp codes,
// mux selects, FSM states and the packed control word.
`timescale 1ns/1ps
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [2:0] ALUOP_RTYPE = 3'b111;
  localparam logic [2:0] ALUOP_ADD   = 3'b100;
  localparam logic [2:0] ALUOP_OR    = 3'b101;
  localparam logic [2:0] ALUOP_AND   = 3'b110;

  localparam logic [1:0] SRCB_B       = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    ST_RST,
    ST_FETCH,
    ST_DECODE,
    ST_MEM_ADDR,
    ST_MEM_RD,
    ST_MEM_WB,
    ST_MEM_WR,
    ST_R_EXEC,
    ST_I_EXEC,
    ST_ALU_WB,
    ST_BRANCH,
    ST_JUMP,
    ST_HALT
  } state_t;

  typedef struct packed {
    logic       pc_write;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic [1:0] pc_source;
  } ctrl_t;

  localparam int CTRL_W = $bits(ctrl_t);

  // States in which the FSM waits on the memory ready handshake.
  function automatic logic is_mem_state(input state_t s);
    return (s == ST_FETCH) || (s == ST_MEM_RD) || (s == ST_MEM_WR);
  endfunction

endpackage

// File: rtl/ctrl_word_decode.sv
// Combinational control-word decode: current state plus opcode and the
// handshake/comparator inputs that gate the Mealy outputs.
`timescale 1ns/1ps
module ctrl_word_decode
  import mips_ctrl_pkg::*;
(
  input  logic [3:0]        state,
  input  logic [5:0]        opcode,
  input  logic              rs_eq_rt,
  input  logic              mem_ready,
  input  logic              rtype_class,
  output logic [CTRL_W-1:0] ctrl
);

  state_t st;
  ctrl_t  c;

  assign st   = state_t'(state);
  assign ctrl = c;

  always_comb begin
    c = '0;
    case (st)
      ST_FETCH: begin
        c.mem_read  = 1'b1;
        c.alu_src_b = SRCB_FOUR;
        c.alu_op    = ALUOP_ADD;
        c.pc_source = PCSRC_ALU;
        c.ir_write  = mem_ready;
        c.pc_write  = mem_ready;
      end
      ST_DECODE: begin
        c.alu_src_b = SRCB_IMM_SH2;
        c.alu_op    = ALUOP_ADD;
      end
      ST_MEM_ADDR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_IMM;
        c.alu_op    = ALUOP_ADD;
      end
      ST_MEM_RD: begin
        c.mem_read = 1'b1;
        c.i_or_d   = 1'b1;
      end
      ST_MEM_WB: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
      end
      ST_MEM_WR: begin
        c.mem_write = 1'b1;
        c.i_or_d    = 1'b1;
      end
      ST_R_EXEC: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_B;
        c.alu_op    = ALUOP_RTYPE;
      end
      ST_I_EXEC: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_IMM;
        case (opcode)
          OP_ORI:  c.alu_op = ALUOP_OR;
          OP_ANDI: c.alu_op = ALUOP_AND;
          default: c.alu_op = ALUOP_ADD;
        endcase
      end
      ST_ALU_WB: begin
        c.reg_write = 1'b1;
        c.reg_dst   = rtype_class;
      end
      ST_BRANCH: begin
        c.pc_source = PCSRC_ALUOUT;
        c.pc_write  = (opcode == OP_BNE) ? !rs_eq_rt : rs_eq_rt;
      end
      ST_JUMP: begin
        c.pc_source = PCSRC_JUMP;
        c.pc_write  = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS main control FSM: state register, next-state sequencing,
// memory-wait watchdog and sticky illegal-opcode / bus-error flags.
`timescale 1ns/1ps
module multicycle_control
  import mips_ctrl_pkg::*;
#(
  parameter int WAIT_W   = 8,
  parameter int MAX_WAIT = 200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       rs_eq_rt,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_op,
  output logic [1:0] pc_source,
  output logic       illegal_op,
  output logic       bus_error
);

  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT);

  state_t            state_reg, state_next;
  logic [WAIT_W-1:0] wd_reg;
  logic              illegal_reg, bus_error_reg;
  logic              rtype_reg, load_reg;
  logic              wd_expire, illegal_set;
  logic [CTRL_W-1:0] ctrl_bits;
  ctrl_t             ctrl;

  ctrl_word_decode u_decode (
    .state       (state_reg),
    .opcode      (opcode),
    .rs_eq_rt    (rs_eq_rt),
    .mem_ready   (mem_ready),
    .rtype_class (rtype_reg),
    .ctrl        (ctrl_bits)
  );

  assign ctrl        = ctrl_t'(ctrl_bits);
  assign wd_expire   = is_mem_state(state_reg) && (wd_reg == WAIT_LIMIT);
  assign illegal_set = (state_reg == ST_DECODE) && (state_next == ST_HALT);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_RST:   state_next = ST_FETCH;
      ST_FETCH: if (mem_ready) state_next = ST_DECODE;
      ST_DECODE: begin
        case (opcode)
          OP_RTYPE:                 state_next = ST_R_EXEC;
          OP_LW, OP_SW:             state_next = ST_MEM_ADDR;
          OP_ADDI, OP_ORI, OP_ANDI: state_next = ST_I_EXEC;
          OP_BEQ, OP_BNE:           state_next = ST_BRANCH;
          OP_J:                     state_next = ST_JUMP;
          default:                  state_next = ST_HALT;
        endcase
      end
      ST_MEM_ADDR: state_next = load_reg ? ST_MEM_RD : ST_MEM_WR;
      ST_MEM_RD:   if (mem_ready) state_next = ST_MEM_WB;
      ST_MEM_WB:   state_next = ST_FETCH;
      ST_MEM_WR:   if (mem_ready) state_next = ST_FETCH;
      ST_R_EXEC:   state_next = ST_ALU_WB;
      ST_I_EXEC:   state_next = ST_ALU_WB;
      ST_ALU_WB:   state_next = ST_FETCH;
      ST_BRANCH:   state_next = ST_FETCH;
      ST_JUMP:     state_next = ST_FETCH;
      ST_HALT:     state_next = ST_HALT;
      default:     state_next = ST_HALT;
    endcase
    // A hung access overrides any handshake arriving on the expiry cycle.
    if (wd_expire) state_next = ST_HALT;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= ST_RST;
      wd_reg        <= '0;
      illegal_reg   <= 1'b0;
      bus_error_reg <= 1'b0;
      rtype_reg     <= 1'b0;
      load_reg      <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (state_next != state_reg) begin
        wd_reg <= '0;
      end else if (is_mem_state(state_reg) && !mem_ready) begin
        wd_reg <= wd_reg + 1'b1;
      end
      // Opcode class is captured once so later states do not depend on the IR.
      if (state_reg == ST_DECODE) begin
        rtype_reg <= (opcode == OP_RTYPE);
        load_reg  <= (opcode == OP_LW);
      end
      if (illegal_set) illegal_reg   <= 1'b1;
      if (wd_expire)   bus_error_reg <= 1'b1;
    end
  end

  assign pc_write   = ctrl.pc_write  & !wd_expire;
  assign ir_write   = ctrl.ir_write  & !wd_expire;
  assign mem_read   = ctrl.mem_read  & !wd_expire;
  assign mem_write  = ctrl.mem_write & !wd_expire;
  assign i_or_d     = ctrl.i_or_d;
  assign reg_dst    = ctrl.reg_dst;
  assign mem_to_reg = ctrl.mem_to_reg;
  assign reg_write  = ctrl.reg_write;
  assign alu_src_a  = ctrl.alu_src_a;
  assign alu_src_b  = ctrl.alu_src_b;
  assign alu_op     = ctrl.alu_op;
  assign pc_source  = ctrl.pc_source;
  assign illegal_op = illegal_reg;
  assign bus_error  = bus_error_reg;

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized instruction stream against a per-instruction expected-cycle model,
// plus directed reset, illegal-opcode, mid-access reset and watchdog scenarios.
`timescale 1ns/1ps
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] opcode = '0;
  logic       rs_eq_rt = 1'b0;
  logic       mem_ready = 1'b0;
  logic       pc_write, i_or_d, mem_read, mem_write, ir_write, reg_dst;
  logic       mem_to_reg, reg_write, alu_src_a, illegal_op, bus_error;
  logic [1:0] alu_src_b, pc_source;
  logic [2:0] alu_op;
  logic [17:0] outv;

  int checks = 0;
  int failures = 0;
  logic exp_illegal = 1'b0;
  logic exp_buserr = 1'b0;

  multicycle_control #(.WAIT_W(8), .MAX_WAIT(5)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .rs_eq_rt(rs_eq_rt),
    .mem_ready(mem_ready), .pc_write(pc_write), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_source(pc_source), .illegal_op(illegal_op), .bus_error(bus_error)
  );

  always #5 clk = ~clk;

  assign outv = {pc_write, i_or_d, mem_read, mem_write, ir_write, reg_dst,
                 mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op,
                 pc_source, illegal_op, bus_error};

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: observed %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Expected output vector from named control fields plus the model's sticky flags.
  function automatic logic [17:0] w(input logic pcw, input logic iord, input logic mr,
                                    input logic mw, input logic irw, input logic rd,
                                    input logic m2r, input logic rw, input logic asa,
                                    input logic [1:0] asb, input logic [2:0] aop,
                                    input logic [1:0] ps);
    return {pcw, iord, mr, mw, irw, rd, m2r, rw, asa, asb, aop, ps, exp_illegal, exp_buserr};
  endfunction

  function automatic logic [17:0] w_zero();
    return w(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 3'b000, 2'b00);
  endfunction

  // Drive one cycle's inputs just after the rising edge, check at the falling edge.
  task automatic cyc(input logic mr, input logic eq, input logic [5:0] op,
                     input logic [17:0] expv, input string tag);
    mem_ready = mr;
    rs_eq_rt  = eq;
    opcode    = op;
    @(negedge clk);
    check_val(tag, 32'(outv), 32'(expv));
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    mem_ready = 1'b0;
    rs_eq_rt = 1'b0;
    opcode = '0;
    exp_illegal = 1'b0;
    exp_buserr = 1'b0;
    #1;
    check_val("rst_async", 32'(outv), 32'(w_zero()));
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check_val("rst_state", 32'(outv), 32'(w_zero()));
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input int fw, input logic [5:0] op);
    for (int i = 0; i < fw; i++)
      cyc(1'b0, 1'($urandom), 6'($urandom), w(0, 0, 1, 0, 0, 0, 0, 0, 0, 2'b01, 3'b100, 2'b00), "fetch_wait");
    cyc(1'b1, 1'($urandom), 6'($urandom), w(1, 0, 1, 0, 1, 0, 0, 0, 0, 2'b01, 3'b100, 2'b00), "fetch_done");
    cyc(1'($urandom), 1'($urandom), op, w(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 3'b100, 2'b00), "decode");
  endtask

  // One instruction from FETCH entry back to the next FETCH, expanded from the opcode's step list.
  task automatic run_instr(input logic [5:0] op, input int fw, input int mw, input logic eq);
    logic [2:0] iop;
    $display("txn op=%b fetch_waits=%0d mem_waits=%0d rs_eq_rt=%b", op, fw, mw, eq);
    fetch(fw, op);
    case (op)
      6'b000000: begin
        cyc(1'($urandom), eq, op, w(0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 3'b111, 2'b00), "r_exec");
        cyc(1'($urandom), eq, op, w(0, 0, 0, 0, 0, 1, 0, 1, 0, 2'b00, 3'b000, 2'b00), "r_wb");
      end
      6'b001000, 6'b001101, 6'b001100: begin
        iop = (op == 6'b001101) ? 3'b101 : (op == 6'b001100) ? 3'b110 : 3'b100;
        cyc(1'($urandom), eq, op, w(0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, iop, 2'b00), "i_exec");
        cyc(1'($urandom), eq, op, w(0, 0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 3'b000, 2'b00), "i_wb");
      end
      6'b100011: begin
        cyc(1'($urandom), eq, op, w(0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 3'b100, 2'b00), "lw_addr");
        for (int i = 0; i < mw; i++)
          cyc(1'b0, eq, op, w(0, 1, 1, 0, 0, 0, 0, 0, 0, 2'b00, 3'b000, 2'b00), "lw_rd_wait");
        cyc(1'b1, eq, op, w(0, 1, 1, 0, 0, 0, 0, 0, 0, 2'b00, 3'b000, 2'b00), "lw_rd_done");
        cyc(1'($urandom), eq, op, w(0, 0, 0, 0, 0, 0, 1, 1, 0, 2'b00, 3'b000, 2'b00), "lw_wb");
      end
      6'b101011: begin
        cyc(1'($urandom), eq, op, w(0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 3'b100, 2'b00), "sw_addr");
        for (int i = 0; i < mw; i++)
          cyc(1'b0, eq, op, w(0, 1, 0, 1, 0, 0, 0, 0, 0, 2'b00, 3'b000, 2'b00), "sw_wr_wait");
        cyc(1'b1, eq, op, w(0, 1, 0, 1, 0, 0, 0, 0, 0, 2'b00, 3'b000, 2'b00), "sw_wr_done");
      end
      6'b000100:
        cyc(1'($urandom), eq, op, w(eq, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 3'b000, 2'b01), "beq");
      6'b000101:
        cyc(1'($urandom), eq, op, w(!eq, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 3'b000, 2'b01), "bne");
      6'b000010:
        cyc(1'($urandom), eq, op, w(1, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 3'b000, 2'b10), "jump");
      default: ;
    endcase
  endtask

  logic [5:0] legal_ops [9];
  logic [5:0] op;

  initial begin
    legal_ops = '{6'b000000, 6'b100011, 6'b101011, 6'b001000, 6'b001101,
                  6'b001100, 6'b000100, 6'b000101, 6'b000010};
    #2;
    do_reset();

    // Directed cases.
    run_instr(6'b000000, 0, 0, 1'b0);
    run_instr(6'b100011, 0, 3, 1'b0);
    run_instr(6'b000100, 0, 0, 1'b0);
    run_instr(6'b000101, 0, 0, 1'b0);
    run_instr(6'b101011, 4, 4, 1'b1);

    for (int n = 0; n < 60; n++) begin
      op = legal_ops[$urandom_range(0, 8)];
      run_instr(op, $urandom_range(0, 4), $urandom_range(0, 4), 1'($urandom));
    end

    // Unsupported opcode: absorbing HALT with a sticky flag.
    $display("txn op=111111 illegal");
    fetch(1, 6'b111111);
    exp_illegal = 1'b1;
    for (int i = 0; i < 20; i++)
      cyc(1'($urandom), 1'($urandom), 6'($urandom), w_zero(), "illegal_halt");
    do_reset();

    // Reset asserted while a store is waiting on memory.
    $display("txn op=101011 reset mid-access");
    fetch(0, 6'b101011);
    cyc(1'b0, 1'b0, 6'b101011, w(0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 3'b100, 2'b00), "sw_addr");
    cyc(1'b0, 1'b0, 6'b101011, w(0, 1, 0, 1, 0, 0, 0, 0, 0, 2'b00, 3'b000, 2'b00), "sw_wr_wait");
    #2;
    check_val("sw_pre_reset", 32'(mem_write), 32'd1);
    do_reset();

    // Memory never answers in FETCH: watchdog expiry.
    $display("txn watchdog fetch stuck");
    for (int i = 0; i < 5; i++)
      cyc(1'b0, 1'b0, 6'($urandom), w(0, 0, 1, 0, 0, 0, 0, 0, 0, 2'b01, 3'b100, 2'b00), "wd_wait");
    mem_ready = 1'b0;
    @(negedge clk);
    check_val("wd_memread_drop", 32'(mem_read), 32'd0);
    @(posedge clk);
    #1;
    exp_buserr = 1'b1;
    for (int i = 0; i < 5; i++)
      cyc(1'($urandom), 1'($urandom), 6'($urandom), w_zero(), "wd_halt");
    do_reset();
    run_instr(6'b000010, 0, 0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
